// File: rtl/seg_display_arbiter_if.sv
// rtl/seg_display_arbiter_if.sv - requester handshake bundle for the display arbiter
//
// Purpose: groups the two message requesters and the cancel line.
// Signals:
//   req1/req2  request levels from the requesters
//   msg1/msg2  32-bit digit payloads ([31:28]=dig7 ... [3:0]=dig0)
//   ack1/ack2  one-cycle grant pulses back to the requesters
//   cancel     abort the message currently on display
// Modports: master = requester side, slave = arbiter side.
interface seg_display_arbiter_if;
  logic        req1;
  logic [31:0] msg1;
  logic        ack1;
  logic        req2;
  logic [31:0] msg2;
  logic        ack2;
  logic        cancel;

  modport master (
    output req1, msg1, req2, msg2, cancel,
    input  ack1, ack2
  );

  modport slave (
    input  req1, msg1, req2, msg2, cancel,
    output ack1, ack2
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - shares the 8-digit display between background and two messages
//
// Purpose: shows bg_digits by default; grants msg1/msg2 round-robin and holds a
// granted message for HOLD_TICKS prescaled ticks of TICK_DIV clocks each.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   req_bus (slave)   req1/msg1/ack1, req2/msg2/ack2, cancel
//   bg_digits         background digits, same packing as the messages
//   dig7..dig0        registered digit values to the display multiplexer
//   active_src        0=background, 1=msg1, 2=msg2
//   busy              high while a message is shown
module seg_display_arbiter #(
  parameter int TICK_DIV   = 4,
  parameter int HOLD_TICKS = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  seg_display_arbiter_if.slave        req_bus,
  input  logic [31:0]                 bg_digits,
  output logic [3:0]                  dig7,
  output logic [3:0]                  dig6,
  output logic [3:0]                  dig5,
  output logic [3:0]                  dig4,
  output logic [3:0]                  dig3,
  output logic [3:0]                  dig2,
  output logic [3:0]                  dig1,
  output logic [3:0]                  dig0,
  output logic [1:0]                  active_src,
  output logic                        busy
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {IDLE, SHOW1, SHOW2} state_t;

  state_t          state, state_next;
  logic [31:0]     digits;
  logic            armed1, armed2;
  logic [1:0]      last_grant;
  logic [PW-1:0]   presc;
  logic [HW-1:0]   hold;
  logic            ack1_q, ack2_q;

  logic            pend1, pend2;
  logic [1:0]      pick;
  logic [1:0]      grant;
  logic            tick, expire;

  assign pend1 = req_bus.req1 & armed1;
  assign pend2 = req_bus.req2 & armed2;

  // Round-robin choice among pending requesters; 0 means nobody is pending.
  always_comb begin
    pick = 2'd0;
    if (pend1 && pend2)
      pick = (last_grant == 2'd1) ? 2'd2 : 2'd1;
    else if (pend1)
      pick = 2'd1;
    else if (pend2)
      pick = 2'd2;
  end

  // Expiry lands on the edge that completes HOLD_TICKS*TICK_DIV cycles of SHOW.
  assign tick   = (state != IDLE) && (presc == PRESC_LAST);
  assign expire = tick && (hold == HOLD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant      = 2'd0;
    case (state)
      IDLE: grant = pick;
      SHOW1, SHOW2: begin
        // cancel beats a simultaneous expiry and never grants on its edge
        if (req_bus.cancel)
          state_next = IDLE;
        else if (expire) begin
          grant = pick;
          if (pick == 2'd0)
            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (grant == 2'd1)
      state_next = SHOW1;
    else if (grant == 2'd2)
      state_next = SHOW2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digits     <= 32'h0;
      active_src <= 2'd0;
      busy       <= 1'b0;
      ack1_q     <= 1'b0;
      ack2_q     <= 1'b0;
      armed1     <= 1'b1;
      armed2     <= 1'b1;
      last_grant <= 2'd1;
      presc      <= '0;
      hold       <= '0;
    end else begin
      ack1_q <= (grant == 2'd1);
      ack2_q <= (grant == 2'd2);

      // A requester must be seen low once after its grant before it can win again.
      if (grant == 2'd1)
        armed1 <= 1'b0;
      else if (!req_bus.req1)
        armed1 <= 1'b1;
      if (grant == 2'd2)
        armed2 <= 1'b0;
      else if (!req_bus.req2)
        armed2 <= 1'b1;

      if (grant != 2'd0) begin
        digits     <= (grant == 2'd1) ? req_bus.msg1 : req_bus.msg2;
        active_src <= grant;
        busy       <= 1'b1;
        last_grant <= grant;
        presc      <= '0;
        hold       <= '0;
      end else if (state_next == IDLE) begin
        digits     <= bg_digits;
        active_src <= 2'd0;
        busy       <= 1'b0;
        presc      <= '0;
        hold       <= '0;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick)
          hold <= hold + HW'(1);
      end
    end
  end

  assign req_bus.ack1 = ack1_q;
  assign req_bus.ack2 = ack2_q;

  assign dig7 = digits[31:28];
  assign dig6 = digits[27:24];
  assign dig5 = digits[23:20];
  assign dig4 = digits[19:16];
  assign dig3 = digits[15:12];
  assign dig2 = digits[11:8];
  assign dig1 = digits[7:4];
  assign dig0 = digits[3:0];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - self-checking bench for seg_display_arbiter
module tb_seg_display_arbiter;
  localparam int D = 4;
  localparam int H = 3;
  localparam logic [31:0] BG = 32'h12345678;
  localparam logic [31:0] M1 = 32'hAAAA0000;
  localparam logic [31:0] M2 = 32'h55555555;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bg;
  logic [3:0]  d7, d6, d5, d4, d3, d2, d1, d0;
  logic [1:0]  src;
  logic        busy;

  seg_display_arbiter_if bus ();

  seg_display_arbiter #(.TICK_DIV(D), .HOLD_TICKS(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_bus    (bus),
    .bg_digits  (bg),
    .dig7       (d7),
    .dig6       (d6),
    .dig5       (d5),
    .dig4       (d4),
    .dig3       (d3),
    .dig2       (d2),
    .dig1       (d1),
    .dig0       (d0),
    .active_src (src),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: display mode, cycles spent showing, arming and fairness memory.
  int          m_mode;
  int          m_shown;
  int          m_last;
  bit          m_arm1, m_arm2;
  logic [31:0] m_dig;
  bit          m_ack1, m_ack2;

  typedef struct {
    bit          r1, r2, c;
    bit          a1, a2;
    logic [1:0]  src;
    bit          busy;
    logic [31:0] dig;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit r1, bit r2, bit c, bit a1, bit a2,
                              logic [1:0] s, bit b, logic [31:0] dg);
    vec_t v;
    v.r1 = r1; v.r2 = r2; v.c = c; v.a1 = a1; v.a2 = a2;
    v.src = s; v.busy = b; v.dig = dg;
    return v;
  endfunction

  function automatic int choose(bit p1, bit p2, int last);
    if (p1 && p2) return (last == 1) ? 2 : 1;
    if (p1) return 1;
    if (p2) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_shown = 0; m_last = 1;
    m_arm1 = 1; m_arm2 = 1; m_dig = 32'h0;
    m_ack1 = 0; m_ack2 = 0;
  endtask

  task automatic model_step(bit r1, bit r2, bit c, logic [31:0] m1, logic [31:0] m2,
                            logic [31:0] b);
    int g;
    bit p1, p2;
    p1 = r1 && m_arm1;
    p2 = r2 && m_arm2;
    g = 0;
    if (m_mode == 0)
      g = choose(p1, p2, m_last);
    else if (c)
      m_mode = 0;
    else begin
      m_shown++;
      if (m_shown == H * D) begin
        g = choose(p1, p2, m_last);
        if (g == 0) m_mode = 0;
      end
    end
    if (g == 1) m_arm1 = 0; else if (!r1) m_arm1 = 1;
    if (g == 2) m_arm2 = 0; else if (!r2) m_arm2 = 1;
    if (g != 0) begin
      m_mode = g; m_shown = 0; m_last = g;
      m_dig = (g == 1) ? m1 : m2;
    end else if (m_mode == 0)
      m_dig = b;
    m_ack1 = (g == 1);
    m_ack2 = (g == 2);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(string tag, logic [31:0] dg, logic [1:0] s, bit b,
                               bit a1, bit a2);
    check({tag, " dig"}, {d7, d6, d5, d4, d3, d2, d1, d0}, dg);
    check({tag, " src"}, {30'h0, src}, {30'h0, s});
    check({tag, " busy"}, {31'h0, busy}, {31'h0, b});
    check({tag, " ack1"}, {31'h0, bus.ack1}, {31'h0, a1});
    check({tag, " ack2"}, {31'h0, bus.ack2}, {31'h0, a2});
  endtask

  // Drive one cycle of inputs, advance past the edge, step the model.
  task automatic drive(bit r1, bit r2, bit c);
    bus.req1 = r1; bus.req2 = r2; bus.cancel = c;
    @(posedge clk);
    #1;
    model_step(r1, r2, c, bus.msg1, bus.msg2, bg);
  endtask

  task automatic cycle(string tag, bit r1, bit r2, bit c);
    drive(r1, r2, c);
    check_outputs(tag, m_dig, 2'(m_mode), m_mode != 0, m_ack1, m_ack2);
  endtask

  initial begin
    int acks;
    bit r1, r2;

    rst = 1'b0;
    bus.req1 = 0; bus.req2 = 0; bus.cancel = 0;
    bus.msg1 = M1; bus.msg2 = M2;
    bg = BG;
    model_reset();
    #2;
    check_outputs("reset", 32'h0, 2'd0, 0, 0, 0);
    #10;
    rst = 1'b1;

    // Directed table: background, single message, tie then back-to-back handover.
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'd0, 0, BG));
    tbl.push_back(mk(1, 0, 0, 1, 0, 2'd1, 1, M1));
    for (int i = 0; i < 11; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 2'd1, 1, M1));
    for (int i = 0; i < 2; i++)  tbl.push_back(mk(0, 0, 0, 0, 0, 2'd0, 0, BG));
    tbl.push_back(mk(1, 1, 0, 0, 1, 2'd2, 1, M2));
    for (int i = 0; i < 11; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 2'd2, 1, M2));
    tbl.push_back(mk(1, 0, 0, 1, 0, 2'd1, 1, M1));
    for (int i = 0; i < 11; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 2'd1, 1, M1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2'd0, 0, BG));

    foreach (tbl[i]) begin
      drive(tbl[i].r1, tbl[i].r2, tbl[i].c);
      check_outputs($sformatf("tbl[%0d]", i), tbl[i].dig, tbl[i].src, tbl[i].busy,
                    tbl[i].a1, tbl[i].a2);
    end

    // req1 held high: one grant only, then idle until it drops and rises again.
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      cycle("hold", 1, 0, 0);
      if (bus.ack1) acks++;
    end
    check("hold ack count", acks, 1);
    check("hold idle busy", {31'h0, busy}, 32'h0);
    cycle("hold drop", 0, 0, 0);
    cycle("hold rise", 1, 0, 0);
    check("hold regrant ack1", {31'h0, bus.ack1}, 32'h1);
    for (int i = 0; i < 14; i++) cycle("hold tail", 0, 0, 0);

    // cancel mid SHOW2 with req1 pending: IDLE next edge, src1 on the following edge.
    cycle("cx grant", 0, 1, 0);
    check("cx src2", {30'h0, src}, 32'h2);
    for (int i = 0; i < 4; i++) cycle("cx wait", 1, 0, 0);
    cycle("cx cancel", 1, 0, 1);
    check("cx idle busy", {31'h0, busy}, 32'h0);
    check("cx idle src", {30'h0, src}, 32'h0);
    cycle("cx next", 1, 0, 0);
    check("cx ack1", {31'h0, bus.ack1}, 32'h1);
    check("cx src1", {30'h0, src}, 32'h1);
    for (int i = 0; i < 14; i++) cycle("cx tail", 0, 0, 0);

    // Asynchronous reset in the middle of SHOW1.
    cycle("rs grant", 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle("rs show", 0, 0, 0);
    check("rs before", {30'h0, src}, 32'h1);
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs("rs async", 32'h0, 2'd0, 0, 0, 0);
    #2;
    rst = 1'b1;
    check("rs lag dig", {d7, d6, d5, d4, d3, d2, d1, d0}, 32'h0);
    cycle("rs resume", 0, 0, 0);
    check("rs bg", {d7, d6, d5, d4, d3, d2, d1, d0}, BG);

    // Randomized traffic against the reference model.
    r1 = 0; r2 = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) r1 = ~r1;
      if ($urandom_range(0, 5) == 0) r2 = ~r2;
      bus.msg1 = $urandom;
      bus.msg2 = $urandom;
      bg = $urandom;
      cycle("rand", r1, r2, $urandom_range(0, 24) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
